// File: rtl/program_sequencer_pkg.sv
// Shared definitions for the program sequencer: sizes, control word layout and FSM states.
package program_sequencer_pkg;

    localparam int SEQ_DEPTH = 16;
    localparam int SEQ_AW    = 4;
    localparam int SEQ_CW    = 8;

    // Bit positions inside a stored program word
    localparam int HALT_BIT = 7;
    localparam int OP_LSB   = 0;
    localparam int WRA      = 3;
    localparam int WRB      = 4;
    localparam int ZA       = 5;
    localparam int ZB       = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } seq_state_t;

    // A word with the halt marker set ends the program instead of being issued
    function automatic logic is_halt(input logic [SEQ_CW-1:0] word);
        return word[HALT_BIT];
    endfunction

    // Pull the seven datapath control bits out of a stored word
    function automatic logic [6:0] ctrl_fields(input logic [SEQ_CW-1:0] word);
        return {word[ZB], word[ZA], word[WRB], word[WRA], word[OP_LSB +: 3]};
    endfunction

endpackage

// File: rtl/program_sequencer_imem.sv
// Program memory: register file with synchronous write, asynchronous read and
// a synchronous clear so a fresh reset always leaves an all-zero program.
module seq_imem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [CW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [CW-1:0] rdata
);

    logic [CW-1:0] mem [DEPTH];

    // Clear every entry on reset, otherwise store the incoming byte when enabled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/program_sequencer.sv
// Program sequencer: loads control words while idle and replays them to the
// ALU/register datapath one per enabled clock until a halt-marked word is reached.
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int DEPTH = SEQ_DEPTH,
    parameter int AW    = SEQ_AW,
    parameter int CW    = SEQ_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          load_valid,
    input  logic [7:0]    load_data,
    output logic          load_ready,
    input  logic          start,
    input  logic          abort,
    output logic [6:0]    ctrl_out,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted
);

    seq_state_t    state, state_next;
    logic [AW-1:0] pc_next;
    logic [AW-1:0] wr_ptr, wr_ptr_next;
    logic [6:0]    ctrl_next;
    logic          mem_we;
    logic [CW-1:0] rd_word;

    seq_imem #(
        .DEPTH(DEPTH),
        .AW   (AW),
        .CW   (CW)
    ) u_imem (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (mem_we),
        .waddr(wr_ptr),
        .wdata(load_data),
        .raddr(pc),
        .rdata(rd_word)
    );

    // Next-state, program counter, load pointer and issued control word.
    // abort outranks start, and both are honoured even while ena stalls issue.
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        wr_ptr_next = wr_ptr;
        ctrl_next   = '0;
        mem_we      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load_valid) begin
                    mem_we      = 1'b1;
                    wr_ptr_next = wr_ptr + AW'(1);
                end
                if (start) begin
                    state_next  = ST_RUN;
                    pc_next     = '0;
                    wr_ptr_next = '0;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_next = ST_IDLE;
                    pc_next    = '0;
                end else if (start) begin
                    pc_next = '0;
                end else if (ena) begin
                    if (is_halt(rd_word)) begin
                        state_next = ST_HALT;
                    end else begin
                        ctrl_next = ctrl_fields(rd_word);
                        pc_next   = pc + AW'(1);
                    end
                end
            end
            ST_HALT: begin
                if (abort) begin
                    state_next = ST_IDLE;
                    pc_next    = '0;
                end else if (start) begin
                    state_next = ST_RUN;
                    pc_next    = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                pc_next    = '0;
            end
        endcase
    end

    // State, pointers and all outputs registered; status flags track the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pc         <= '0;
            wr_ptr     <= '0;
            ctrl_out   <= '0;
            busy       <= 1'b0;
            halted     <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            wr_ptr     <= wr_ptr_next;
            ctrl_out   <= ctrl_next;
            busy       <= (state_next == ST_RUN);
            halted     <= (state_next == ST_HALT);
            load_ready <= (state_next == ST_IDLE);
        end
    end

endmodule
